// File: rtl/safety_island_err_recorder_if.sv
// Register-bus request/response bundle between a bus master and the safety island error recorder.
// One outstanding request at a time; the response follows acceptance by exactly one cycle.
interface safety_island_err_recorder_if #(
  parameter int AddrWidth = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic [AddrWidth-1:0] req_addr;
  logic                 req_write;
  logic [31:0]          req_wdata;
  logic                 rsp_valid;
  logic [31:0]          rsp_rdata;
  logic                 rsp_error;

  modport master (
    output req_valid, req_addr, req_write, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/safety_island_err_recorder.sv
// Data-port bus-error recorder: captures error events into a small FIFO that software
// inspects and drains through a register window; interrupts while records are pending.
module safety_island_err_recorder #(
  parameter  int AddrWidth = 32,
  parameter  int Depth     = 4,
  localparam int CntWidth  = $clog2(Depth) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 err_valid_i,
  input  logic [AddrWidth-1:0] err_addr_i,
  input  logic                 err_we_i,
  safety_island_err_recorder_if.slave bus,
  output logic                 irq_o
);

  localparam int PtrWidth = $clog2(Depth);

  localparam logic [2:0] RegStatus = 3'd0;
  localparam logic [2:0] RegAddr   = 3'd1;
  localparam logic [2:0] RegInfo   = 3'd2;
  localparam logic [2:0] RegPop    = 3'd3;
  localparam logic [2:0] RegCtrl   = 3'd4;

  // Record storage
  logic [AddrWidth-1:0] fifo_addr [Depth];
  logic                 fifo_we   [Depth];
  logic [PtrWidth-1:0]  rd_ptr;
  logic [PtrWidth-1:0]  wr_ptr;
  logic [CntWidth-1:0]  count;
  logic [CntWidth-1:0]  count_next;
  logic                 overflow;
  logic [1:0]           ctrl;

  // Response registers
  logic                 rsp_valid;
  logic [31:0]          rsp_rdata;
  logic                 rsp_error;

  logic                 accept;
  logic [2:0]           reg_off;
  logic                 nonempty;
  logic                 full;
  logic                 pop_wr;
  logic                 pop;
  logic                 ovf_clr;
  logic                 push_req;
  logic                 push;
  logic                 drop;
  logic                 ctrl_we;
  logic [31:0]          rdata_next;
  logic                 error_next;
  logic                 unused_bits;

  assign unused_bits = ^{bus.req_addr[AddrWidth-1:5], bus.req_addr[1:0], bus.req_wdata[31:2]};

  // A single outstanding request: ready drops while its response is on the bus.
  assign bus.req_ready = ~rsp_valid;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_error = rsp_error;

  assign accept   = bus.req_valid & ~rsp_valid;
  assign reg_off  = bus.req_addr[4:2];
  assign nonempty = (count != '0);
  assign full     = (count == CntWidth'(Depth));

  assign pop_wr   = accept & bus.req_write & (reg_off == RegPop);
  assign pop      = pop_wr & bus.req_wdata[0] & nonempty;
  assign ovf_clr  = pop_wr & bus.req_wdata[1];
  assign ctrl_we  = accept & bus.req_write & (reg_off == RegCtrl);

  // A pop in the same cycle frees the slot the new record lands in.
  assign push_req = err_valid_i & ctrl[0];
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CntWidth'(1);
      2'b01:   count_next = count - CntWidth'(1);
      default: count_next = count;
    endcase
  end

  // Read data is formed from the state before this cycle's updates.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    rdata_next = '0;
    error_next = 1'b0;
    case (reg_off)
      RegStatus: if (!bus.req_write) begin
        rdata_next[0]             = nonempty;
        rdata_next[1]             = overflow;
        rdata_next[8 +: CntWidth] = count;
      end
      RegAddr: if (!bus.req_write && nonempty) begin
        rdata_next = 32'(fifo_addr[rd_ptr]);
      end
      RegInfo: if (!bus.req_write && nonempty) begin
        rdata_next[0] = fifo_we[rd_ptr];
        rdata_next[1] = 1'b1;
      end
      RegPop:  rdata_next = '0;
      RegCtrl: if (!bus.req_write) begin
        rdata_next[1:0] = ctrl;
      end
      default: error_next = 1'b1;
    endcase
  end

  // NOTE: record storage has no reset; the pointers and count define which slots are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wr_ptr] <= err_addr_i;
      fifo_we[wr_ptr]   <= err_we_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      ctrl      <= 2'b01;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
      if (push) wr_ptr <= wr_ptr + PtrWidth'(1);
      count     <= count_next;
      // A new drop wins over a same-cycle clear.
      overflow  <= (overflow & ~ovf_clr) | drop;
      if (ctrl_we) ctrl <= bus.req_wdata[1:0];
      rsp_valid <= accept;
      rsp_rdata <= (accept && !error_next) ? rdata_next : '0;
      rsp_error <= accept & error_next;
      irq_o     <= ctrl[1] & (nonempty | overflow);
    end
  end

endmodule
